// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared state encoding and helper functions for the synchronous data memory.
package data_mem_pkg;
  typedef enum logic {ST_CLEAR, ST_READY} state_t;
  localparam int MAX_W = 256;
  function automatic int clog2_depth(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w, input logic [MAX_W-1:0] new_w, input logic [MAX_W/8-1:0] mask);
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_W / 8; i++) r[i*8 +: 8] = mask[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/data_mem_clear_ctrl.sv
// data_mem_clear_ctrl: post-reset clear sweep FSM and pointer driving the storage fill.
module data_mem_clear_ctrl
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int AW = 11
) (
  input  logic          Clk,
  input  logic          Reset,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);
  state_t state, state_nx;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= busy ? clr_addr + 1'b1 : clr_addr;
    end
  end
  always_comb begin
    state_nx = (state == ST_CLEAR && clr_addr == AW'(DEPTH - 1)) ? ST_READY : state;
  end
  assign busy   = state == ST_CLEAR;
  assign clr_we = busy;
endmodule

// File: rtl/data_mem_sync.sv
// data_mem_sync: registered CPU read/write port plus debug read port, cleared by hardware after reset.
// Optional byte-lane write masking is enabled by defining DATA_MEM_BYTE_WR_EN.
module data_mem_sync
  import data_mem_pkg::*;
#(
  parameter int ADDR_BUS = 11,
  parameter int DATA_SIZE = 16,
  parameter int DEPTH = 2048,
  parameter logic [DATA_SIZE-1:0] INIT_VALUE = '0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Rd,
  input  logic                 Wr,
  input  logic [ADDR_BUS-1:0]  Addr,
  input  logic [DATA_SIZE-1:0] In_Data,
`ifdef DATA_MEM_BYTE_WR_EN
  input  logic [DATA_SIZE/8-1:0] Wr_Mask,
`endif
  output logic [DATA_SIZE-1:0] Out_Data,
  output logic                 Rd_Valid,
  output logic                 Addr_Err,
  output logic                 Busy,
  input  logic [ADDR_BUS-1:0]  Dbg_Addr,
  output logic [DATA_SIZE-1:0] Dbg_Data
);
  localparam int AW = clog2_depth(DEPTH);
  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic                 clr_we, in_range, dbg_in_range, cpu_we;
  logic [AW-1:0]        clr_addr, idx, didx;
  logic [DATA_SIZE-1:0] wr_word;

  data_mem_clear_ctrl #(.DEPTH(DEPTH), .AW(AW)) u_clear_ctrl (
    .Clk      (Clk),
    .Reset    (Reset),
    .busy     (Busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Range check precedes truncation so out-of-range addresses never alias onto storage.
  assign in_range     = 32'(Addr) < DEPTH;
  assign dbg_in_range = 32'(Dbg_Addr) < DEPTH;
  assign idx          = Addr[AW-1:0];
  assign didx         = Dbg_Addr[AW-1:0];
  assign cpu_we       = !Reset && !Busy && Wr && in_range;

`ifdef DATA_MEM_BYTE_WR_EN
  if (DATA_SIZE % 8 != 0) begin : g_bad_width
    $fatal(1, "data_mem_sync: DATA_SIZE must be a multiple of 8 with byte write enables");
  end
  assign wr_word = DATA_SIZE'(byte_merge(MAX_W'(mem[idx]), MAX_W'(In_Data), (MAX_W/8)'(Wr_Mask)));
`else
  assign wr_word = In_Data;
`endif

  always_ff @(posedge Clk) begin
    if (clr_we) mem[clr_addr] <= INIT_VALUE;
    else if (cpu_we) mem[idx] <= wr_word;
  end

  always_ff @(posedge Clk) begin
    if (Reset || Busy) begin
      Out_Data <= '0;
      Dbg_Data <= '0;
      Rd_Valid <= 1'b0;
      Addr_Err <= 1'b0;
    end else begin
      Out_Data <= (Rd && in_range) ? (cpu_we ? wr_word : mem[idx]) : '0;
      Dbg_Data <= dbg_in_range ? ((cpu_we && Dbg_Addr == Addr) ? wr_word : mem[didx]) : '0;
      Rd_Valid <= Rd;
      Addr_Err <= (Rd || Wr) && !in_range;
    end
  end
endmodule

// File: tb/tb_data_mem_sync.sv
// tb_data_mem_sync: directed and random stimulus against a cycle-level reference model of data_mem_sync.
module tb_data_mem_sync;
  localparam int DEPTH = 16;
  localparam logic [15:0] INIT = 16'hA5A5;

  logic        Clk = 0, Reset = 0, Rd = 0, Wr = 0;
  logic [4:0]  Addr = '0, Dbg_Addr = '0;
  logic [15:0] In_Data = '0, Out_Data, Dbg_Data;
  logic [1:0]  Wr_Mask = '0;
  logic        Rd_Valid, Addr_Err, Busy;

  int n_cmp = 0, n_err = 0;

  logic [15:0] mdl [DEPTH];
  int          clr_left = 0;
  logic [15:0] e_out, e_dbg;
  logic        e_val, e_err;

  data_mem_sync #(.ADDR_BUS(5), .DATA_SIZE(16), .DEPTH(DEPTH), .INIT_VALUE(INIT)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Rd       (Rd),
    .Wr       (Wr),
    .Addr     (Addr),
    .In_Data  (In_Data),
`ifdef DATA_MEM_BYTE_WR_EN
    .Wr_Mask  (Wr_Mask),
`endif
    .Out_Data (Out_Data),
    .Rd_Valid (Rd_Valid),
    .Addr_Err (Addr_Err),
    .Busy     (Busy),
    .Dbg_Addr (Dbg_Addr),
    .Dbg_Data (Dbg_Data)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] merged(input logic [15:0] old_w, input logic [15:0] new_w, input logic [1:0] m);
`ifdef DATA_MEM_BYTE_WR_EN
    return {m[1] ? new_w[15:8] : old_w[15:8], m[0] ? new_w[7:0] : old_w[7:0]};
`else
    return new_w;
`endif
  endfunction

  task automatic step(input logic r, input logic rd, input logic wr, input logic [4:0] a,
                      input logic [15:0] d, input logic [4:0] da, input logic [1:0] m);
    logic [15:0] w;
    logic        inr;
    @(negedge Clk);
    Reset = r; Rd = rd; Wr = wr; Addr = a; In_Data = d; Dbg_Addr = da; Wr_Mask = m;
    @(posedge Clk);
    e_out = '0; e_dbg = '0; e_val = 0; e_err = 0;
    if (r) clr_left = DEPTH;
    else if (clr_left > 0) begin
      clr_left--;
      if (clr_left == 0) for (int i = 0; i < DEPTH; i++) mdl[i] = INIT;
    end else begin
      inr = a < DEPTH;
      w = inr ? merged(mdl[a[3:0]], d, m) : d;
      e_out = (rd && inr) ? (wr ? w : mdl[a[3:0]]) : '0;
      e_val = rd;
      e_err = (rd || wr) && !inr;
      e_dbg = (da < DEPTH) ? ((wr && inr && da == a) ? w : mdl[da[3:0]]) : '0;
      if (wr && inr) mdl[a[3:0]] = w;
    end
    #1;
    chk("out", Out_Data, e_out);
    chk("valid", 16'(Rd_Valid), 16'(e_val));
    chk("err", 16'(Addr_Err), 16'(e_err));
    chk("busy", 16'(Busy), 16'(clr_left > 0));
    chk("dbg", Dbg_Data, e_dbg);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 3, 16'hDEAD, 3, 3);
    chk("busy_after_reset", 16'(Busy), 16'd1);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 5'(i), 16'h0BAD, 5'(i), 3);
    chk("busy_done", 16'(Busy), 16'd0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 0, 5'(i), 0, 5'(i), 0);
      chk("init_read", Out_Data, 16'hA5A5);
    end
    step(0, 0, 1, 3, 16'h1234, 0, 3);
    step(0, 1, 0, 3, 0, 3, 0);
    chk("rd_after_wr", Out_Data, 16'h1234);
    chk("rd_after_wr_valid", 16'(Rd_Valid), 16'd1);
    step(0, 0, 0, 3, 0, 0, 0);
    chk("idle_zero", Out_Data, 16'h0000);
    step(0, 1, 1, 7, 16'hBEEF, 7, 3);
    chk("write_first", Out_Data, 16'hBEEF);
    chk("dbg_forward", Dbg_Data, 16'hBEEF);
    step(0, 0, 1, 20, 16'hFFFF, 20, 3);
    chk("addr_err_pulse", 16'(Addr_Err), 16'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("addr_err_clear", 16'(Addr_Err), 16'd0);
    step(0, 1, 0, 20, 0, 0, 0);
    chk("oob_read", Out_Data, 16'h0000);
    step(0, 1, 0, 4, 0, 4, 0);
    chk("no_alias", Out_Data, 16'hA5A5);
    step(0, 0, 1, 5, 16'h5555, 0, 3);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 1, 5, 16'h1111, 5, 3);
    chk("busy_restart", 16'(Busy), 16'd1);
    step(0, 0, 1, 5, 16'h1111, 5, 3);
    chk("busy_restart_done", 16'(Busy), 16'd0);
    step(0, 1, 0, 5, 0, 5, 0);
    chk("wr_during_busy_lost", Out_Data, 16'hA5A5);
`ifdef DATA_MEM_BYTE_WR_EN
    step(0, 0, 1, 2, 16'h1122, 0, 2'b01);
    step(0, 1, 0, 2, 0, 2, 0);
    chk("mask_lo", Out_Data, 16'hA522);
    step(0, 0, 1, 2, 16'h33FF, 0, 2'b10);
    step(0, 1, 0, 2, 0, 2, 0);
    chk("mask_hi", Out_Data, 16'h3322);
`endif
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 199) == 0), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 19)),
           16'($urandom), 5'($urandom_range(0, 19)), 2'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/data_mem_sync.md
Name: data_mem_sync

Overview:
Synchronous, parametrised successor of the processor data memory. It has one registered read/write CPU port and one read-only debug port. After reset, a hardware clear sweep fills every word with INIT_VALUE, so memory contents do not depend on simulation initialisation. It sits between the CPU datapath (accumulator load/store) and the debug unit.

Parameters:
- ADDR_BUS, 11: address width in bits.
- DATA_SIZE, 16: word width in bits.
- DEPTH, 2048: number of implemented words; must be <= 2**ADDR_BUS and >= 2.
- INIT_VALUE, 0: word written to every location by the clear sweep.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Rd  in  1  CPU read request, sampled at the rising edge.
- Wr  in  1  CPU write request, sampled at the rising edge.
- Addr  in  ADDR_BUS  CPU word address.
- In_Data  in  DATA_SIZE  CPU write data.
- Out_Data  out  DATA_SIZE  registered CPU read data.
- Rd_Valid  out  1  one-cycle pulse: Out_Data holds the result of the read issued on the previous edge.
- Addr_Err  out  1  one-cycle pulse: the previous-edge Rd or Wr had Addr >= DEPTH.
- Busy  out  1  high while the clear sweep runs; CPU and debug requests are ignored.
- Dbg_Addr  in  ADDR_BUS  debug read address, read every cycle.
- Dbg_Data  out  DATA_SIZE  registered debug read data.

Behaviour:
- Reset (Clk edge with Reset=1):
  - State goes to ST_CLEAR; clear pointer Clr_Ptr=0.
  - Out_Data=0, Dbg_Data=0, Rd_Valid=0, Addr_Err=0, Busy=1.
  - Reset wins over every other input.
- ST_CLEAR:
  - Each edge writes mem[Clr_Ptr]=INIT_VALUE, then Clr_Ptr increments.
  - At Clr_Ptr==DEPTH-1 the edge writes the last word and moves to ST_READY.
  - Busy is deasserted starting the cycle after that edge. The sweep therefore takes exactly DEPTH edges after Reset deasserts.
  - Rd, Wr and Dbg_Addr are ignored. Out_Data and Dbg_Data stay 0; Rd_Valid and Addr_Err stay 0.
  - Reset reasserted mid-sweep restarts the sweep from Clr_Ptr=0.
- ST_READY, CPU port (latency 1 cycle):
  - Wr=1, Addr<DEPTH: mem[Addr] <= In_Data.
  - Rd=1, Addr<DEPTH: Out_Data <= mem[Addr]; Rd_Valid=1 next cycle.
  - Rd=1 and Wr=1 on the same address: write-first; Out_Data <= In_Data.
  - Rd=0: Out_Data <= 0 and Rd_Valid=0. This keeps the legacy "0 when not reading" semantics, one cycle late.
  - Addr >= DEPTH with Rd or Wr: write dropped, Out_Data <= 0, Addr_Err=1 next cycle. Rd_Valid still pulses if Rd=1.
- ST_READY, debug port:
  - Dbg_Data <= mem[Dbg_Addr] every edge.
  - Dbg_Addr >= DEPTH gives Dbg_Data <= 0.
  - Same-edge collision with a CPU write to the same address: Dbg_Data <= the written word (forwarded).
- Width rule: only the low ceil(log2 DEPTH) bits index storage, after the range check. No wrap-around aliasing.
- The FSM has exactly two states, ST_CLEAR and ST_READY. There is no return to ST_CLEAR except via Reset.

Optional Feature:
- DATA_MEM_BYTE_WR_EN defined:
  - Adds input Wr_Mask [DATA_SIZE/8-1:0]. On a write, byte lane i is updated only if Wr_Mask[i]=1; other lanes keep their old value.
  - Write-first and debug forwarding return the merged word.
  - DATA_SIZE must be a multiple of 8; otherwise elaboration fails with a fatal.
  - The clear sweep ignores the mask.
- Not defined: no Wr_Mask port; every write updates the full word.

Decomposition:
- Package data_mem_pkg:
  - State enum {ST_CLEAR, ST_READY}.
  - Function clog2_depth.
  - Function byte_merge (old word, new word, mask), used under DATA_MEM_BYTE_WR_EN.
- Sub-module data_mem_clear_ctrl: FSM plus Clr_Ptr counter. Outputs Busy, clear write enable and clear address.
- The top level holds the storage array, port muxing, range check, forwarding and output registers.

Test Plan (bench uses DEPTH=16, ADDR_BUS=5, DATA_SIZE=16, INIT_VALUE=16'hA5A5):
- Reset for 2 cycles, release: Busy=1 for exactly 16 cycles, then 0. Rd at Addr 0..15 each returns 16'hA5A5 with Rd_Valid pulses.
- Wr Addr=3 In_Data=16'h1234, next cycle Rd Addr=3: Out_Data=16'h1234 with Rd_Valid=1. Same cycle Rd=0: next Out_Data=0, Rd_Valid=0.
- Rd=1 Wr=1 Addr=7 In_Data=16'hBEEF, Dbg_Addr=7: next cycle Out_Data=16'hBEEF and Dbg_Data=16'hBEEF.
- Wr Addr=20 In_Data=16'hFFFF: Addr_Err pulses 1 cycle. Rd Addr=20 gives Out_Data=0. Rd Addr=4 is unchanged (16'hA5A5, no aliasing).
- Reset asserted at sweep cycle 8: Busy stays 1 for 16 full cycles after release. Wr issued during Busy is lost; the location reads 16'hA5A5.
- DATA_MEM_BYTE_WR_EN: Wr Addr=2 In_Data=16'h1122 Wr_Mask=2'b01 gives read 16'hA522. Wr_Mask=2'b10 with In_Data=16'h33FF gives 16'h3322.
